axi_req_arbiter: RTL
====================

Name: axi_req_arbiter

Overview:
- Two-requester arbiter that shares the single AXI4-Lite user command port (wr_en/wr_addr/wr_data, rd_en/rd_addr/rd_data) between two independent masters.
- Sits in front of the AXI top-level user interface, which feeds the AXI master/slave pair and the RAM.
- Serialises requests with round-robin priority and issues exactly one transaction at a time.
- Waits for downstream completion, then returns an acknowledge pulse and read data to the winning requester.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit before forced error completion; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_i  input  2  per-requester request; bit n = requester n.
- we_i  input  2  per-requester direction: 1 = write, 0 = read.
- addr_i  input  2*ADDR_W  per-requester address; requester n uses slice [n*ADDR_W +: ADDR_W].
- wdata_i  input  2*DATA_W  per-requester write data, same slicing.
- ack_o  output  2  one-cycle completion pulse to the owning requester.
- err_o  output  2  error flag, valid with ack_o.
- rdata_o  output  2*DATA_W  per-requester read data, registered, held until that requester's next ack.
- wr_en_o  output  1  downstream write strobe.
- wr_addr_o  output  ADDR_W  downstream write address.
- wr_data_o  output  DATA_W  downstream write data.
- rd_en_o  output  1  downstream read strobe.
- rd_addr_o  output  ADDR_W  downstream read address.
- rd_data_i  input  DATA_W  downstream read data, valid when done_i is high.
- done_i  input  1  downstream completion of the outstanding transaction.

Behaviour:
- Reset, asynchronous:
  - State = IDLE.
  - All outputs = 0; rdata_o = 0.
  - Owner register = 0.
  - Round-robin pointer last_gnt = 1, so requester 0 wins the first contest.
- Requester rule: hold req/we/addr/wdata stable from assertion until ack_o[n] is sampled high; deassert or launch a new request on the following cycle.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Eligible requesters = req_i & ~ack_o. This masks a requester still high during its own ack cycle.
  - If both are eligible, grant the one not equal to last_gnt. If one is eligible, grant it.
  - On grant: latch owner, we, addr and wdata into internal registers; go to ISSUE.
  - If none is eligible, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Write: wr_en_o = 1, with wr_addr_o/wr_data_o = latched values.
  - Read: rd_en_o = 1, with rd_addr_o = latched address.
  - Go to WAIT.
  - done_i is ignored in ISSUE.
- WAIT:
  - wr_en_o and rd_en_o = 0; address and data outputs keep their latched values.
  - On done_i = 1: register ack_o[owner] = 1 for the next cycle.
  - Read case: on the same edge, rdata_o[owner] <= rd_data_i. Write case: rdata_o is unchanged.
  - On the same edge: last_gnt <= owner; go to IDLE.
- Latency: request sampled in IDLE at cycle 0 → strobe in cycle 1 → earliest done in cycle 2 → ack in cycle 3. Back-to-back throughput is one transaction per 3 cycles minimum.
- Simultaneous requests: round-robin alternates strictly. Under continuous load, grants are 0, 1, 0, 1, …
- A request arriving while another transaction is in ISSUE or WAIT waits in IDLE arbitration; it is never dropped.
- done_i while in IDLE is ignored.
- Reset mid-transaction: FSM aborts to IDLE with all outputs 0; no ack is issued.
- ack_o is never high on both bits in the same cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - If the counter reaches TIMEOUT_CYCLES with done_i still low, the arbiter forces completion: ack_o[owner] = 1 and err_o[owner] = 1 for one cycle, rdata_o[owner] <= 0 for reads, last_gnt updates, and the FSM returns to IDLE.
  - done_i and the timeout in the same cycle: done wins, err = 0.
- Not defined:
  - No counter; WAIT lasts indefinitely until done_i.
  - err_o is tied to 0.

Test Plan:
- Reset then single write: req_i=01, we=1, addr=0x10, wdata=0xDEADBEEF, done_i 2 cycles after wr_en_o → wr_en_o high exactly 1 cycle with addr 0x10 and data 0xDEADBEEF; ack_o=01 one cycle; err_o=00.
- Read: requester 1 reads addr 0x10, rd_data_i=0xDEADBEEF with done_i → rd_en_o for 1 cycle; rdata_o[1]=0xDEADBEEF; ack_o=10.
- Contention: req_i=11 held continuously, done_i 1 cycle after each strobe → grant order 0, 1, 0, 1; no double ack; each ack 3 cycles apart.
- Ack masking: requester 0 holds req through its ack cycle then drops → exactly one transaction issued for it.
- Reset asserted during WAIT → outputs go to 0 asynchronously; no ack; after release a new request is served normally.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and done_i never asserted on a read → ack_o and err_o high together 8 WAIT cycles after the strobe; rdata_o=0; next request is served.

Source files
------------

// File: rtl/axi_req_arbiter.sv
// rtl/axi_req_arbiter.sv - two-requester round-robin front end for the AXI user command port
// Optional ARB_TIMEOUT_EN: WAIT gives up after TIMEOUT_CYCLES and completes with err_o set.
module axi_req_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [2*ADDR_W-1:0] addr_i,
  input  logic [2*DATA_W-1:0] wdata_i,
  output logic [1:0]          ack_o,
  output logic [1:0]          err_o,
  output logic [2*DATA_W-1:0] rdata_o,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic                rd_en_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic [DATA_W-1:0]   rd_data_i,
  input  logic                done_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t              state_q;
  logic                owner_q;
  logic                we_q;
  logic                last_gnt_q;
  logic [1:0]          ack_q;
  logic [1:0]          err_q;
  logic [2*DATA_W-1:0] rdata_q;
  logic                wr_en_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [DATA_W-1:0]   wr_data_q;

  logic [1:0]          elig_d;
  logic                gnt_vld_d;
  logic                gnt_idx_d;
  logic [ADDR_W-1:0]   gnt_addr_d;
  logic [DATA_W-1:0]   gnt_wdata_d;
  logic [DATA_W-1:0]   rd_fill_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q;
`endif

  // A requester still high during its own ack cycle must not win again.
  always_comb begin
    elig_d      = req_i & ~ack_q;
    gnt_vld_d   = |elig_d;
    gnt_idx_d   = (elig_d == 2'b11) ? ~last_gnt_q : elig_d[1];
    gnt_addr_d  = gnt_idx_d ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
    gnt_wdata_d = gnt_idx_d ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
    rd_fill_d   = done_i ? rd_data_i : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      last_gnt_q <= 1'b1;
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      ack_q   <= '0;
      err_q   <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            owner_q <= gnt_idx_d;
            we_q    <= we_i[gnt_idx_d];
            if (we_i[gnt_idx_d]) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= gnt_addr_d;
              wr_data_q <= gnt_wdata_d;
            end else begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= gnt_addr_d;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef ARB_TIMEOUT_EN
          cnt_q <= '0;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
`ifdef ARB_TIMEOUT_EN
          if (done_i || cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_q[owner_q] <= ~done_i;
`else
          if (done_i) begin
`endif
            ack_q[owner_q] <= 1'b1;
            // Reads load the data (or zero on a forced completion); writes leave rdata alone.
            if (!we_q) begin
              if (owner_q) rdata_q[2*DATA_W-1:DATA_W] <= rd_fill_d;
              else         rdata_q[DATA_W-1:0]        <= rd_fill_d;
            end
            last_gnt_q <= owner_q;
            state_q    <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;

endmodule
